// File: rtl/parking_slot_manager_pkg.sv
// Shared definitions for the parking slot manager: class indices, default
// capacities and the per-class event decode.
package parking_slot_manager_pkg;

  localparam int CLASS_GENERAL     = 0;
  localparam int CLASS_HANDICAPPED = 1;
  localparam int CLASS_EV          = 2;

  localparam int DEF_NUM_CLASSES     = 3;
  localparam int DEF_CNT_W           = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam logic [DEF_NUM_CLASSES*DEF_CNT_W-1:0] DEF_CAP_VEC = {5'd5, 5'd5, 5'd20};

  typedef enum logic [1:0] {
    EV_NONE  = 2'b00,
    EV_ENTER = 2'b01,
    EV_EXIT  = 2'b10,
    EV_BOTH  = 2'b11
  } slot_event_t;

  function automatic slot_event_t decode_event(input logic ent, input logic ext);
    return slot_event_t'({ext, ent});
  endfunction

endpackage

// File: rtl/parking_slot_manager_sensor_conditioner.sv
// Raw sensor conditioning: two-flop synchroniser, debounce, and a one-cycle
// pulse on the accepted 0->1 transition of the debounced level.
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic            level_q;
  logic [DB_W-1:0] db_cnt;

  // Down-counter reloads on any match; level flips on the DEBOUNCE_CYCLES-th
  // consecutive mismatch. Everything resets high so a sensor held high
  // across reset never looks like a new arrival.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_q <= 1'b1;
      db_cnt  <= DB_LOAD;
      pulse   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        db_cnt <= DB_LOAD;
      end else if (db_cnt == '0) begin
        level  <= sync2;
        db_cnt <= DB_LOAD;
      end else begin
        db_cnt <= db_cnt - 1'b1;
      end
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/parking_slot_manager.sv
// Multi-class free-slot tracker: per-class saturating counts, full/empty
// flags, sticky error bits and a lot-wide free total.
module parking_slot_manager
  import parking_slot_manager_pkg::*;
#(
  parameter int NUM_CLASSES     = DEF_NUM_CLASSES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter logic [NUM_CLASSES*CNT_W-1:0] CAP_VEC = DEF_CAP_VEC,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CLASSES-1:0]         entry,
  input  logic [NUM_CLASSES-1:0]         exit,
  input  logic                           err_clr,
  output logic [NUM_CLASSES*CNT_W-1:0]   free_slots,
  output logic [NUM_CLASSES-1:0]         full,
  output logic [NUM_CLASSES-1:0]         empty,
  output logic [CNT_W+1:0]               total_free,
  output logic [NUM_CLASSES-1:0]         err_sticky
);

  function automatic logic [CNT_W+1:0] cap_sum(input logic [NUM_CLASSES*CNT_W-1:0] caps);
    logic [CNT_W+1:0] s;
    s = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      s = s + (CNT_W+2)'(caps[i*CNT_W +: CNT_W]);
    end
    return s;
  endfunction

  localparam logic [CNT_W+1:0] CAP_TOTAL = cap_sum(CAP_VEC);

  logic [NUM_CLASSES-1:0]       ent_p;
  logic [NUM_CLASSES-1:0]       ext_p;
  logic [NUM_CLASSES*CNT_W-1:0] free_next;
  logic [NUM_CLASSES-1:0]       full_next;
  logic [NUM_CLASSES-1:0]       empty_next;
  logic [NUM_CLASSES-1:0]       err_set;
  logic [CNT_W+1:0]             total_next;

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_class
    localparam logic [CNT_W-1:0] CAP = CAP_VEC[g*CNT_W +: CNT_W];

    logic [CNT_W-1:0] cur;
    logic [CNT_W-1:0] nxt;
    logic             err_g;

    sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
      .clk   (clk),
      .reset (reset),
      .raw   (entry[g]),
      .pulse (ent_p[g])
    );

    sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
      .clk   (clk),
      .reset (reset),
      .raw   (exit[g]),
      .pulse (ext_p[g])
    );

    assign cur = free_slots[g*CNT_W +: CNT_W];

    // Simultaneous entry and exit nets to zero and is never an error.
    always_comb begin
      nxt   = cur;
      err_g = 1'b0;
      case (decode_event(ent_p[g], ext_p[g]))
        EV_ENTER: begin
          if (cur != '0) nxt = cur - 1'b1;
          else           err_g = 1'b1;
        end
        EV_EXIT: begin
          if (cur < CAP) nxt = cur + 1'b1;
          else           err_g = 1'b1;
        end
        default: ;
      endcase
    end

    assign free_next[g*CNT_W +: CNT_W] = nxt;
    assign full_next[g]                = (nxt == '0);
    assign empty_next[g]               = (nxt == CAP);
    assign err_set[g]                  = err_g;
  end

  // Total and flags are built from next-state counts so they register
  // in the same cycle as free_slots.
  always_comb begin
    total_next = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      total_next = total_next + (CNT_W+2)'(free_next[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_slots <= CAP_VEC;
      full       <= '0;
      empty      <= '1;
      total_free <= CAP_TOTAL;
      err_sticky <= '0;
    end else begin
      free_slots <= free_next;
      full       <= full_next;
      empty      <= empty_next;
      total_free <= total_next;
      err_sticky <= err_set | (err_sticky & {NUM_CLASSES{~err_clr}});
    end
  end

endmodule
